// File: rtl/pll_lock_ctrl.sv
// pll_lock_ctrl
//   Power-up and lock sequencer for a PLL, clocked from the free-running
//   reference clock. It powers the PLL down, releases power-down and then
//   reset, waits for lock with a timeout and bounded retries, and qualifies
//   lock over a stability window before raising clk_ready. Loss of lock
//   while running, or a relock request, re-sequences the PLL.
//
//   clkin1      in   reference clock, free-running
//   rst         in   synchronous active-high reset
//   pll_lock    in   PLL lock, asynchronous to clkin1
//   relock_req  in   one-cycle pulse forcing a new power-up sequence
//   pll_pwd     out  PLL power-down, active-high
//   pll_rst     out  PLL reset, active-high
//   clk_ready   out  PLL outputs usable
//   pll_fail    out  retries exhausted; held until relock_req or rst
//   retry_cnt   out  failed attempts since the last entry into RUN
//   loss_cnt    out  lock losses seen while running, saturating
module pll_lock_ctrl #(
  parameter int unsigned PWD_CYCLES    = 3,
  parameter int unsigned RST_CYCLES    = 3,
  parameter int unsigned LOCK_TIMEOUT  = 1000,
  parameter int unsigned STABLE_CYCLES = 16,
  parameter int unsigned MAX_RETRY     = 3,
  parameter int unsigned CNT_W         = 8
) (
  input  logic             clkin1,
  input  logic             rst,
  input  logic             pll_lock,
  input  logic             relock_req,
  output logic             pll_pwd,
  output logic             pll_rst,
  output logic             clk_ready,
  output logic             pll_fail,
  output logic [3:0]       retry_cnt,
  output logic [CNT_W-1:0] loss_cnt
);

  // The shared timer must reach the longest of the per-state windows.
  localparam int unsigned T_A   = (PWD_CYCLES > RST_CYCLES) ? PWD_CYCLES : RST_CYCLES;
  localparam int unsigned T_B   = (LOCK_TIMEOUT > STABLE_CYCLES) ? LOCK_TIMEOUT : STABLE_CYCLES;
  localparam int unsigned T_MAX = (T_A > T_B) ? T_A : T_B;
  localparam int unsigned TMR_W = $clog2(T_MAX + 1);

  localparam logic [TMR_W-1:0] PWD_LAST = TMR_W'(PWD_CYCLES - 1);
  localparam logic [TMR_W-1:0] RST_LAST = TMR_W'(RST_CYCLES - 1);
  localparam logic [TMR_W-1:0] TO_LAST  = TMR_W'(LOCK_TIMEOUT - 1);
  localparam logic [TMR_W-1:0] STB_LAST = TMR_W'(STABLE_CYCLES - 1);
  localparam logic [3:0]       MAX_R    = 4'(MAX_RETRY);

  localparam logic [2:0] S_PWD    = 3'd0;
  localparam logic [2:0] S_RST    = 3'd1;
  localparam logic [2:0] S_WAIT   = 3'd2;
  localparam logic [2:0] S_STABLE = 3'd3;
  localparam logic [2:0] S_RUN    = 3'd4;
  localparam logic [2:0] S_FAIL   = 3'd5;

  logic [2:0]       state_q, state_d;
  logic [TMR_W-1:0] timer_q, timer_d;
  logic [3:0]       retry_q, retry_d;
  logic [CNT_W-1:0] loss_q, loss_d;
  logic             lock_meta_q, lock_meta_d;
  logic             lock_s_q, lock_s_d;
  logic             pwd_q, pwd_d;
  logic             prst_q, prst_d;
  logic             ready_q, ready_d;
  logic             fail_q, fail_d;
  logic             restart;

  always_comb begin
    state_d     = state_q;
    retry_d     = retry_q;
    loss_d      = loss_q;
    restart     = 1'b0;
    lock_meta_d = pll_lock;
    lock_s_d    = lock_meta_q;

    case (state_q)
      S_PWD: begin
        if (relock_req)               restart = 1'b1;
        else if (timer_q == PWD_LAST) state_d = S_RST;
      end
      S_RST: begin
        if (relock_req)               state_d = S_PWD;
        else if (timer_q == RST_LAST) state_d = S_WAIT;
      end
      S_WAIT: begin
        // Relock takes priority over both lock detection and timeout.
        if (relock_req)               state_d = S_PWD;
        else if (lock_s_q)            state_d = S_STABLE;
        else if (timer_q == TO_LAST) begin
          retry_d = retry_q + 4'd1;
          state_d = (retry_d == MAX_R) ? S_FAIL : S_PWD;
        end
      end
      S_STABLE: begin
        if (relock_req)               state_d = S_PWD;
        else if (!lock_s_q)           state_d = S_WAIT;
        else if (timer_q == STB_LAST) begin
          state_d = S_RUN;
          retry_d = '0;
        end
      end
      S_RUN: begin
        // A lock loss is counted even when a relock arrives together with it.
        if (!lock_s_q) begin
          state_d = S_PWD;
          if (loss_q != '1) loss_d = loss_q + CNT_W'(1);
        end
        if (relock_req) state_d = S_PWD;
      end
      S_FAIL: begin
        if (relock_req) begin
          state_d = S_PWD;
          retry_d = '0;
        end
      end
      default: state_d = S_PWD;
    endcase

    if ((state_d != state_q) || restart)           timer_d = '0;
    else if ((state_q == S_RUN) || (state_q == S_FAIL)) timer_d = '0;
    else                                           timer_d = timer_q + TMR_W'(1);

    // Outputs are registered decodes of the current state, one cycle behind it.
    pwd_d   = (state_q == S_PWD) || (state_q == S_FAIL);
    prst_d  = pwd_d || (state_q == S_RST);
    ready_d = (state_q == S_RUN);
    fail_d  = (state_q == S_FAIL);
  end

  always_ff @(posedge clkin1) begin
    if (rst) begin
      state_q     <= S_PWD;
      timer_q     <= '0;
      retry_q     <= '0;
      loss_q      <= '0;
      lock_meta_q <= 1'b0;
      lock_s_q    <= 1'b0;
      pwd_q       <= 1'b1;
      prst_q      <= 1'b1;
      ready_q     <= 1'b0;
      fail_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      retry_q     <= retry_d;
      loss_q      <= loss_d;
      lock_meta_q <= lock_meta_d;
      lock_s_q    <= lock_s_d;
      pwd_q       <= pwd_d;
      prst_q      <= prst_d;
      ready_q     <= ready_d;
      fail_q      <= fail_d;
    end
  end

  assign pll_pwd   = pwd_q;
  assign pll_rst   = prst_q;
  assign clk_ready = ready_q;
  assign pll_fail  = fail_q;
  assign retry_cnt = retry_q;
  assign loss_cnt  = loss_q;

endmodule

// File: tb/tb_pll_lock_ctrl.sv
// Testbench for pll_lock_ctrl: hand-derived vector table, directed
// multi-cycle sequences, and randomized lock/relock/reset traffic checked
// against a phase/dwell-time reference model.
module tb_pll_lock_ctrl;

  localparam int unsigned P_PWD  = 3;
  localparam int unsigned P_RST  = 3;
  localparam int unsigned P_TO   = 20;
  localparam int unsigned P_STB  = 16;
  localparam int unsigned P_MAXR = 3;
  localparam int unsigned P_CW   = 2;
  localparam int unsigned OW     = 8 + P_CW;

  logic            clk = 1'b0;
  logic            rst_i, lock_i, relock_i;
  logic            pll_pwd, pll_rst, clk_ready, pll_fail;
  logic [3:0]      retry_cnt;
  logic [P_CW-1:0] loss_cnt;

  pll_lock_ctrl #(
    .PWD_CYCLES(P_PWD), .RST_CYCLES(P_RST), .LOCK_TIMEOUT(P_TO),
    .STABLE_CYCLES(P_STB), .MAX_RETRY(P_MAXR), .CNT_W(P_CW)
  ) dut (
    .clkin1(clk), .rst(rst_i), .pll_lock(lock_i), .relock_req(relock_i),
    .pll_pwd(pll_pwd), .pll_rst(pll_rst), .clk_ready(clk_ready),
    .pll_fail(pll_fail), .retry_cnt(retry_cnt), .loss_cnt(loss_cnt)
  );

  always #5 clk = ~clk;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  // Reference model: a phase name plus the clock edge on which it began.
  typedef enum int {PH_PWD, PH_RST, PH_WAIT, PH_STABLE, PH_RUN, PH_FAIL} phase_e;
  phase_e      ph;
  int unsigned cyc_no = 0;
  int unsigned ph_start, m_retry, m_loss;
  logic        hist[$];
  logic        e_pwd, e_rst, e_rdy, e_fail;

  task automatic model_edge();
    phase_e      nxt;
    int unsigned dwell;
    logic        ls;
    cyc_no++;
    if (rst_i) begin
      ph = PH_PWD; ph_start = cyc_no; m_retry = 0; m_loss = 0;
      hist = '{1'b0, 1'b0};
      {e_pwd, e_rst, e_rdy, e_fail} = 4'b1100;
      return;
    end
    ls = hist.pop_front();
    hist.push_back(lock_i);
    e_pwd  = (ph == PH_PWD) || (ph == PH_FAIL);
    e_rst  = e_pwd || (ph == PH_RST);
    e_rdy  = (ph == PH_RUN);
    e_fail = (ph == PH_FAIL);
    dwell  = cyc_no - ph_start;
    nxt    = ph;
    case (ph)
      PH_PWD:    if (relock_i) ph_start = cyc_no; else if (dwell == P_PWD) nxt = PH_RST;
      PH_RST:    if (relock_i) nxt = PH_PWD; else if (dwell == P_RST) nxt = PH_WAIT;
      PH_WAIT: begin
        if (relock_i) nxt = PH_PWD;
        else if (ls) nxt = PH_STABLE;
        else if (dwell == P_TO) begin
          m_retry++;
          nxt = (m_retry == P_MAXR) ? PH_FAIL : PH_PWD;
        end
      end
      PH_STABLE: begin
        if (relock_i) nxt = PH_PWD;
        else if (!ls) nxt = PH_WAIT;
        else if (dwell == P_STB) begin nxt = PH_RUN; m_retry = 0; end
      end
      PH_RUN: begin
        if (!ls && (m_loss < (1 << P_CW) - 1)) m_loss++;
        if (!ls || relock_i) nxt = PH_PWD;
      end
      PH_FAIL:   if (relock_i) begin nxt = PH_PWD; m_retry = 0; end
      default:   nxt = PH_PWD;
    endcase
    if (nxt != ph) begin ph = nxt; ph_start = cyc_no; end
  endtask

  function automatic logic [OW-1:0] expected();
    return {e_pwd, e_rst, e_rdy, e_fail, 4'(m_retry), P_CW'(m_loss)};
  endfunction

  function automatic logic [OW-1:0] actual();
    return {pll_pwd, pll_rst, clk_ready, pll_fail, retry_cnt, loss_cnt};
  endfunction

  task automatic check(input string name, input logic [OW-1:0] act, input logic [OW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @edge %0d: pwd/rst/rdy/fail/retry/loss got %b required %b",
               name, cyc_no, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int unsigned act, input int unsigned exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s @edge %0d: got %0d required %0d", name, cyc_no, act, exp);
    end
  endtask

  // One clock: drive inputs, let the edge happen, update the model, compare.
  task automatic cyc(input logic r, input logic l, input logic q);
    rst_i = r; lock_i = l; relock_i = q;
    @(posedge clk);
    model_edge();
    #1;
    check("model", actual(), expected());
  endtask

  task automatic wait_ready(input int unsigned bound);
    int unsigned n;
    n = 0;
    while (!clk_ready && (n < bound)) begin
      cyc(1'b0, 1'b1, 1'b0);
      n++;
    end
    if (!clk_ready) begin
      n_cmp++; n_bad++;
      $display("FAIL wait_ready: clk_ready got 0 required 1 within %0d cycles", bound);
    end
  endtask

  typedef struct {
    logic        r, l, q;
    int unsigned n;
    logic [OW-1:0] exp;
  } vec_t;

  function automatic vec_t mk(input logic r, input logic l, input logic q, input int unsigned n,
                              input logic [3:0] flags, input logic [3:0] rt, input logic [1:0] ls);
    vec_t v;
    v.r = r; v.l = l; v.q = q; v.n = n;
    v.exp = {flags, rt, ls};
    return v;
  endfunction

  vec_t tbl[20];

  initial begin
    int unsigned n;
    logic        lv;
    int unsigned len;

    // flags = {pll_pwd, pll_rst, clk_ready, pll_fail}
    tbl[0]  = mk(1, 0, 0,  2, 4'b1100, 0, 0);  // reset state
    tbl[1]  = mk(0, 0, 0,  3, 4'b1100, 0, 0);  // power-down window
    tbl[2]  = mk(0, 0, 0,  1, 4'b0100, 0, 0);  // pwd released, rst held
    tbl[3]  = mk(0, 0, 0,  3, 4'b0000, 0, 0);  // rst released, waiting
    tbl[4]  = mk(0, 0, 0, 18, 4'b0000, 0, 0);
    tbl[5]  = mk(0, 0, 0,  1, 4'b0000, 1, 0);  // first timeout
    tbl[6]  = mk(0, 0, 0,  1, 4'b1100, 1, 0);
    tbl[7]  = mk(0, 0, 0,  5, 4'b0100, 1, 0);
    tbl[8]  = mk(0, 1, 0, 19, 4'b0000, 0, 0);  // locked, RUN entered, retry cleared
    tbl[9]  = mk(0, 1, 0,  1, 4'b0010, 0, 0);  // clk_ready up
    tbl[10] = mk(0, 0, 0,  2, 4'b0010, 0, 0);  // lock drop still in synchroniser
    tbl[11] = mk(0, 0, 0,  1, 4'b0010, 0, 1);  // loss counted
    tbl[12] = mk(0, 0, 0,  1, 4'b1100, 0, 1);  // ready drops, re-sequencing
    tbl[13] = mk(0, 0, 0, 65, 4'b0000, 2, 1);  // mid-WAIT with two retries
    tbl[14] = mk(1, 0, 0,  1, 4'b1100, 0, 0);  // reset clears everything
    tbl[15] = mk(0, 0, 0, 78, 4'b0000, 3, 0);  // third timeout
    tbl[16] = mk(0, 0, 0,  1, 4'b1101, 3, 0);  // pll_fail up
    tbl[17] = mk(0, 1, 0, 10, 4'b1101, 3, 0);  // sticky
    tbl[18] = mk(0, 0, 1,  1, 4'b1101, 0, 0);  // relock clears retries
    tbl[19] = mk(0, 0, 0,  1, 4'b1100, 0, 0);  // pll_fail down

    for (int i = 0; i < 20; i++) begin
      repeat (tbl[i].n) cyc(tbl[i].r, tbl[i].l, tbl[i].q);
      check($sformatf("vec%0d", i), actual(), tbl[i].exp);
    end

    // Lock glitch at STABLE count 8, then relock time measured from restore.
    repeat (12) cyc(1'b0, 1'b1, 1'b0);
    repeat (5)  cyc(1'b0, 1'b0, 1'b0);
    n = 0;
    do begin
      cyc(1'b0, 1'b1, 1'b0);
      n++;
    end while (!clk_ready && (n < 100));
    check_int("glitch_to_ready", n, 20);
    check_int("glitch_retry", retry_cnt, 0);

    // Repeated lock losses in RUN; loss_cnt saturates at 3.
    for (int d = 0; d < 5; d++) begin
      repeat (3) cyc(1'b0, 1'b0, 1'b0);
      check_int("ready_before_drop", clk_ready, 1);
      cyc(1'b0, 1'b0, 1'b0);
      check_int("ready_after_drop", clk_ready, 0);
      check_int("loss_count", loss_cnt, (d >= 2) ? 3 : d + 1);
      wait_ready(80);
    end

    // Relock request in RUN.
    cyc(1'b0, 1'b1, 1'b1);
    cyc(1'b0, 1'b1, 1'b0);
    check_int("relock_ready_low", clk_ready, 0);
    check_int("relock_loss_kept", loss_cnt, 3);
    wait_ready(80);

    // Randomized traffic against the model.
    for (int s = 0; s < 250; s++) begin
      lv = ($urandom_range(0, 3) != 0);
      if (lv)                            len = $urandom_range(1, 60);
      else if ($urandom_range(0, 7) == 0) len = $urandom_range(60, 120);
      else                               len = $urandom_range(1, 30);
      for (int k = 0; k < int'(len); k++)
        cyc(($urandom_range(0, 499) == 0), lv, ($urandom_range(0, 39) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
